dmem_responder: RTL and testbench

Data-memory responder for the pipelined RISC-V core; the target side of the MEM-stage load/store interface.
- Accepts one load or store request at a time over a valid/ready handshake.
- Models a configurable number of wait states.
- Returns aligned and extended read data with a one-cycle response pulse.
- Drives a stall output so the core can freeze its front stages while an access is outstanding.

---
 rtl/riscv_mem_pkg.sv | 37 +++
 rtl/dmem_lane_align.sv | 45 ++++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, latched request.
// Pure declarations; no latency or backpressure of its own.
// Optional misalignment detection lives behind DMEM_MISALIGN_CHECK_EN in dmem_responder.
package riscv_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Half must sit on an even address, word on a multiple of four; size 2'b11 behaves as word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: replicates store data with byte enables, extracts and extends load data.
// Purely combinational, zero latency.
// No handshake; the parent decides when the results are consumed.
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wword,
    output logic [3:0]  be,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rword[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
        wword    = wdata;
        be       = 4'b1111;
        rdata    = rword;
        case (size)
            SZ_BYTE: begin
                wword = {4{wdata[7:0]}};
                be    = 4'b0001 << addr_lo;
                rdata = {{24{~uns & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                wword = {2{wdata[15:0]}};
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                rdata = {{16{~uns & half_sel[15]}}, half_sel};
            end
            default: begin
                wword = wdata;
                be    = 4'b1111;
                rdata = rword;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory target: one load/store at a time, WAIT_CYCLES wait states, DMEM_MISALIGN_CHECK_EN adds misalignment errors.
// Latency: resp_valid is a one-cycle pulse WAIT_CYCLES+1 cycles after the accept cycle; one access per WAIT_CYCLES+2 cycles.
// Backpressure: req_ready only in IDLE; stall holds the core while a request is outstanding.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    req_t              in_req, cur_req;
    logic [31:0]       rdata_q, rdata_d;
    logic              go_resp;
    logic              misalign;
    logic              mem_we;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       wword, load_data;
    logic [3:0]        be;
    logic              addr_hi_unused;

    assign in_req = '{we: req_we, size: req_size, uns: req_unsigned,
                      addr: req_addr, wdata: req_wdata};

    // With zero wait states the access completes straight from the incoming request.
    assign cur_req        = (state_q == IDLE) ? in_req : req_q;
    assign idx            = cur_req.addr[IDX_W+1:2];
    assign addr_hi_unused = ^cur_req.addr[31:IDX_W+2];

    dmem_lane_align u_align (
        .addr_lo (cur_req.addr[1:0]),
        .size    (cur_req.size),
        .uns     (cur_req.uns),
        .wdata   (cur_req.wdata),
        .rword   (mem_q[idx]),
        .wword   (wword),
        .be      (be),
        .rdata   (load_data)
    );

`ifdef DMEM_MISALIGN_CHECK_EN
    logic err_q;

    assign misalign = is_misaligned(cur_req.size, cur_req.addr[1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (go_resp) begin
            err_q <= misalign;
        end
    end

    assign resp_err = err_q;
`else
    assign misalign = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        rdata_d   = rdata_q;
        go_resp   = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    req_d = in_req;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (go_resp) begin
            rdata_d = (cur_req.we | misalign) ? 32'h0 : load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is not reset; a store lands only on the edge that enters RESP.
    assign mem_we = go_resp & cur_req.we & ~misalign & ~reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign stall      = req_valid & ~resp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array reference model.
// Default parameters (DEPTH=64, WAIT_CYCLES=2); honours DMEM_MISALIGN_CHECK_EN.
module tb_dmem_responder;

    localparam int DEPTH  = 64;
    localparam int NBYTES = DEPTH * 4;
    localparam int LAT    = 3;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    int n_vec;
    int n_err;

    logic [7:0] mb [NBYTES];

    dmem_responder #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .stall        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: a flat byte array, addresses wrap modulo the memory size.
    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic int base_of(input logic [31:0] a, input logic [1:0] sz);
        int n;
        n = nbytes_of(sz);
        return int'(a % NBYTES) / n * n;
    endfunction

    function automatic bit m_misaligned(input logic [31:0] a, input logic [1:0] sz);
`ifdef DMEM_MISALIGN_CHECK_EN
        return (a % nbytes_of(sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
        int n, base;
        logic [31:0] v;
        n    = nbytes_of(sz);
        base = base_of(a, sz);
        v    = 0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[base + i]) << (8 * i));
        if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int n, base;
        n    = nbytes_of(sz);
        base = base_of(a, sz);
        for (int i = 0; i < n; i++) mb[base + i] = wd[8*i +: 8];
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic access(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd, input bit drop,
                          output logic [31:0] rd, output logic er);
        int cyc;
        bit got;
        bit mis;
        logic [31:0] exp_rd;
        mis    = m_misaligned(a, sz);
        exp_rd = (we || mis) ? 32'h0 : m_load(a, sz, uns);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr  = a;    req_wdata = wd;
        #1;
        check_eq("ready_idle", 32'(req_ready), 32'd1);
        check_eq("stall_req",  32'(stall),     32'd1);
        @(posedge clk);
        #1;
        // Inputs are free to change after accept; the latched request must be used.
        req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom);
        req_size = 2'($urandom); req_unsigned = 1'($urandom);
        if (drop) req_valid = 1'b0;
        cyc = 0;
        got = 1'b0;
        rd  = 'x;
        er  = 1'bx;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) begin
                got = 1'b1;
                rd  = resp_rdata;
                er  = resp_err;
                check_eq("stall_resp", 32'(stall), 32'd0);
            end else begin
                check_eq("stall_wait", 32'(stall), 32'(req_valid));
                check_eq("ready_busy", 32'(req_ready), 32'd0);
            end
        end
        check_eq("latency", 32'(cyc), 32'(LAT));
        check_eq("rdata", rd, exp_rd);
        check_eq("err", 32'(er), 32'(mis));
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("pulse_one", 32'(resp_valid), 32'd0);
        check_eq("rdata_hold", resp_rdata, rd);
        check_eq("ready_back", 32'(req_ready), 32'd1);
        if (we && !mis) m_store(a, sz, wd);
    endtask

    logic [31:0] rd;
    logic        er;
    bit          seen;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        #1;
        check_eq("rst_ready", 32'(req_ready),  32'd1);
        check_eq("rst_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_rdata", resp_rdata,      32'd0);
        check_eq("rst_err",   32'(resp_err),   32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("post_rst_stall", 32'(stall), 32'd0);
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) access(1'b1, 2'b10, 1'b0, 32'(i * 4), 32'h0, 1'b0, rd, er);

        access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, rd, er);
        check_eq("sw_rdata0", rd, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd, er);
        check_eq("lw_10", rd, 32'hDEADBEEF);
        access(1'b1, 2'b00, 1'b0, 32'h13, 32'h80, 1'b0, rd, er);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd, er);
        check_eq("sb_13_word", rd, 32'h80ADBEEF);
        access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, rd, er);
        check_eq("lb_13", rd, 32'hFFFFFF80);
        access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, rd, er);
        check_eq("lbu_13", rd, 32'h00000080);
        access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, rd, er);
        check_eq("lh_12", rd, 32'hFFFF80AD);
        access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, rd, er);
        check_eq("lhu_10", rd, 32'h0000BEEF);

        // Reset in the middle of a store's wait states.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        check_eq("mid_rst_ready", 32'(req_ready),  32'd1);
        check_eq("mid_rst_valid", 32'(resp_valid), 32'd0);
        check_eq("mid_rst_rdata", resp_rdata,      32'd0);
        check_eq("mid_rst_stall", 32'(stall),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check_eq("mid_rst_no_resp", 32'(seen), 32'd0);
        check_eq("mid_rst_ready2", 32'(req_ready), 32'd1);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, rd, er);
        check_eq("lw_20_aborted", rd, 32'h0);

        access(1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D, 1'b0, rd, er);
        access(1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 1'b0, rd, er);
        check_eq("wrap_lw_0", rd, 32'hCAFEF00D);

        access(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b0, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
        check_eq("mis_lw_rdata", rd, 32'h0);
        check_eq("mis_lw_err", 32'(er), 32'd1);
        access(1'b1, 2'b10, 1'b0, 32'h11, 32'h55555555, 1'b0, rd, er);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd, er);
        check_eq("mis_sw_nowrite", rd, 32'h80ADBEEF);
`else
        check_eq("unal_lw_rdata", rd, 32'h80ADBEEF);
        check_eq("unal_lw_err", 32'(er), 32'd0);
`endif

        for (int i = 0; i < 150; i++) begin
            access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                   1'($urandom), rd, er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
